alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational 32-bit ALU (AND/NOR/OR/ADD/SUB/SLT, 4-bit ALUop) between two requesters.
//  Round-robin arbitration, valid/ready request and response handshakes, and registered operands.
//  Picks the result (Y or Less) and cleans it up, so requesters never see X values.
//  Sits between the ALU instance and its clients (e.g. execute stage and address/branch unit).
// PARAMETERS
//  W      32  operand/result width; must match the ALU
//  OP_W   4   ALUop width; encoding: [1:0] 00=AND(NOR if [3]), 01=OR, 10=ADD/SUB([2]=1 SUB), 11=SLT
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     synchronous reset, active low
//  req0_valid   in   1     requester 0 has an operation
//  req0_ready   out  1     requester 0 op accepted this cycle
//  req0_a/b     in   W     requester 0 operands
//  req0_op      in   OP_W  requester 0 ALUop
//  req1_*       -    -     same set as req0_* for requester 1
//  rsp0_valid   out  1     result for requester 0 on rsp_y/rsp_ovf
//  rsp0_ready   in   1     requester 0 takes the result
//  rsp1_valid   out  1     result for requester 1
//  rsp1_ready   in   1     requester 1 takes the result
//  rsp_y        out  W     result (shared; qualified by rspN_valid)
//  rsp_ovf      out  1     signed overflow; only meaningful for ADD/SUB
//  busy         out  1     state != IDLE
//  alu_a/alu_b  out  W     to ALU A/B
//  alu_op       out  OP_W  to ALU ALUop
//  alu_y        in   W     from ALU Y
//  alu_less     in   W     from ALU Less
//  alu_ovf      in   1     from ALU Overflow
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, ptr=0 (req0 favoured). All rsp/ready/busy=0.
//   rsp_y=0, alu_a=alu_b=0, alu_op=0, operand/result regs=0. Reset beats every other event.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: grant is combinational. Only one valid -> it wins. Both valid -> req[ptr] wins.
//    reqN_ready=1 only for the granted requester, only in IDLE. Nothing valid: no grant, stay IDLE.
//    On accept: latch a, b, op and owner id; go to EXEC.
//   EXEC (1 cycle): alu_a/alu_b/alu_op driven from latched regs, which are stable the whole cycle.
//    At the clock edge capture the result, then go to RESP:
//     op[1:0]==11: rsp_y=alu_less (1 if A<B signed, else 0); rsp_ovf=0.
//     op[1:0]==10: rsp_y=alu_y; rsp_ovf=alu_ovf.
//     op[1:0]==00/01: rsp_y=alu_y; rsp_ovf=0.
//    SLT fix-up: for op[1:0]==11 the latched op has bit2 forced to 1, so the ALU subtracts.
//   RESP: rsp<owner>_valid=1; rsp_y/rsp_ovf held stable. The other rsp valid stays 0.
//    On rsp<owner>_ready=1: go to IDLE, ptr=~owner. No new accept in this cycle.
//    Hold indefinitely while ready=0. Requests wait in this state (ready=0).
//  Latency: accept at cycle 0 -> rspN_valid from cycle 2. Peak throughput 1 op / 3 cycles.
//  Fairness: under continuous contention, grants alternate 0,1,0,1...
//   A lone requester may win back-to-back; ptr still flips after each serve.
//  Outside EXEC, alu_* keep their last values (no toggling); they carry no meaning then.
//  Requesters must hold a/b/op stable while valid=1 and ready=0. Dropping valid before grant is legal.
// TESTING
//  T1 Reset: rst_n=0 two cycles mid-RESP -> state IDLE, all valids/readies 0, rsp_y=0, next grant to req0.
//  T2 Single op: req0 A=0xF0F0_0000 B=0xFF00_FF00 op=4'b0000 -> req0_ready at c0.
//   rsp0_valid at c2, rsp_y=0xF000_0000, rsp_ovf=0. Same operands with op=4'b1000 -> rsp_y=0x000F_00FF.
//  T3 Contention: both valid continuously, each op ADD 1+1 -> grants 0,1,0,1.
//   rsp_y=2 each; rsp1_valid never asserted while rsp0_valid=1.
//  T4 SLT fix-up: req1 A=5 B=7 op=4'b0011 -> alu_op=4'b0111 in EXEC, rsp_y=1.
//   A=0xFFFF_FFFF(-1) B=1 -> 1; A=7 B=5 -> 0. rsp_ovf=0 in all cases.
//  T5 Overflow: ADD 0x7FFF_FFFF+1 -> rsp_y=0x8000_0000, rsp_ovf=1.
//   SUB (op=4'b0110) 0x8000_0000-1 -> rsp_y=0x7FFF_FFFF, rsp_ovf=1.
//  T6 Backpressure: rsp0_ready=0 for 5 cycles -> rsp0_valid and rsp_y stable, req1 not granted.
//   Ready=1 -> IDLE next cycle, then req1 granted.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the shared-ALU arbiter: two request channels, two response
// channels, the shared result bus and the busy flag.
interface alu_arbiter_if #(
  parameter int unsigned W    = 32,
  parameter int unsigned OP_W = 4
);
  logic            req0_valid;
  logic            req0_ready;
  logic [W-1:0]    req0_a;
  logic [W-1:0]    req0_b;
  logic [OP_W-1:0] req0_op;
  logic            req1_valid;
  logic            req1_ready;
  logic [W-1:0]    req1_a;
  logic [W-1:0]    req1_b;
  logic [OP_W-1:0] req1_op;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [W-1:0]    rsp_y;
  logic            rsp_ovf;
  logic            busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y, rsp_ovf, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y, rsp_ovf, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold until taken).
module alu_arbiter #(
  parameter int unsigned W    = 32,
  parameter int unsigned OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arbiter_if.slave    bus,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [W-1:0]    alu_y,
  input  logic [W-1:0]    alu_less,
  input  logic            alu_ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            owner_q, owner_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [W-1:0]    y_q, y_d;
  logic            ovf_q, ovf_d;
  logic            gnt0, gnt1;

  // ptr names the requester favoured when both are valid
  assign gnt0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr_q);
  assign gnt1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? bus.req1_a  : bus.req0_a;
          b_d     = gnt1 ? bus.req1_b  : bus.req0_b;
          op_d    = gnt1 ? bus.req1_op : bus.req0_op;
          // SLT needs the ALU subtracting to produce Less
          if (op_d[1:0] == 2'b11) op_d[2] = 1'b1;
          owner_d = gnt1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (op_q[1:0])
          2'b11: begin
            y_d   = alu_less;
            ovf_d = 1'b0;
          end
          2'b10: begin
            y_d   = alu_y;
            ovf_d = alu_ovf;
          end
          default: begin
            y_d   = alu_y;
            ovf_d = 1'b0;
          end
        endcase
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand regs only change on accept, so the ALU inputs stay quiet outside EXEC
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) && owner_q;
  assign bus.rsp_y      = y_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 32-bit ALU attached to the alu_* ports.
module tb_alu_arbiter;
  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_y, alu_less;
  logic [3:0]  alu_op;
  logic        alu_ovf;
  logic [31:0] diff, sum;
  int          n_cmp;
  int          n_err;

  alu_arbiter_if #(.W(32), .OP_W(4)) bus ();

  alu_arbiter #(.W(32), .OP_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_y    (alu_y),
    .alu_less (alu_less),
    .alu_ovf  (alu_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sum  = alu_a + alu_b;
    diff = alu_a - alu_b;
    case (alu_op[1:0])
      2'b00:   alu_y = alu_op[3] ? ~(alu_a | alu_b) : (alu_a & alu_b);
      2'b01:   alu_y = alu_a | alu_b;
      2'b10:   alu_y = alu_op[2] ? diff : sum;
      default: alu_y = diff;
    endcase
    alu_less = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
    if (alu_op[2]) alu_ovf = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
    else           alu_ovf = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lone request: accept, EXEC, RESP, taken in the first RESP cycle
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] ey, input logic eovf,
                       input logic [3:0] eop);
    drive(id, 1'b1, a, b, op);
    #1;
    chk("req_ready_c0", (id == 0) ? bus.req0_ready : bus.req1_ready, 32'd1);
    tick();
    drive(id, 1'b0, a, b, op);
    chk("exec_busy", bus.busy, 32'd1);
    chk("exec_alu_op", alu_op, eop);
    chk("exec_alu_a", alu_a, a);
    chk("exec_no_rsp", bus.rsp0_valid | bus.rsp1_valid, 32'd0);
    tick();
    chk("rsp_valid", (id == 0) ? bus.rsp0_valid : bus.rsp1_valid, 32'd1);
    chk("rsp_other", (id == 0) ? bus.rsp1_valid : bus.rsp0_valid, 32'd0);
    chk("rsp_y", bus.rsp_y, ey);
    chk("rsp_ovf", bus.rsp_ovf, eovf);
    if (id == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    chk("back_idle", bus.busy, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 32'd0);
    chk("rst_rsp_y", bus.rsp_y, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", alu_op, 32'd0);

    // Logic ops
    do_op(0, 32'hF0F0_0000, 32'hFF00_FF00, 4'b0000, 32'hF000_0000, 1'b0, 4'b0000);
    do_op(0, 32'hF0F0_0000, 32'hFF00_FF00, 4'b1000, 32'h000F_00FF, 1'b0, 4'b1000);

    // SLT with bit2 forced on the ALU side
    do_op(1, 32'd5, 32'd7, 4'b0011, 32'd1, 1'b0, 4'b0111);
    do_op(1, 32'hFFFF_FFFF, 32'd1, 4'b0011, 32'd1, 1'b0, 4'b0111);
    do_op(1, 32'd7, 32'd5, 4'b0011, 32'd0, 1'b0, 4'b0111);

    // Signed overflow
    do_op(0, 32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 1'b1, 4'b0010);
    do_op(1, 32'h8000_0000, 32'd1, 4'b0110, 32'h7FFF_FFFF, 1'b1, 4'b0110);

    // Continuous contention with consumers always ready: grants must alternate 0,1,0,1
    drive(0, 1'b1, 32'd1, 32'd1, 4'b0010);
    drive(1, 1'b1, 32'd1, 32'd1, 4'b0010);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    for (int r = 0; r < 4; r++) begin
      chk("cont_gnt", {bus.req1_ready, bus.req0_ready}, (r % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("cont_exec_norsp", {bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      tick();
      chk("cont_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, (r % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_rsp_y", bus.rsp_y, 32'd2);
      tick();
    end
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Backpressure on requester 0 while requester 1 waits
    drive(0, 1'b1, 32'h0000_00F0, 32'h0000_0F00, 4'b0001);
    drive(1, 1'b1, 32'd3, 32'd4, 4'b0010);
    #1;
    chk("bp_gnt0", {bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp0_valid", bus.rsp0_valid, 32'd1);
      chk("bp_rsp_y", bus.rsp_y, 32'h0000_0FF0);
      chk("bp_req1_wait", bus.req1_ready, 32'd0);
      tick();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    chk("bp_still_valid", bus.rsp0_valid, 32'd1);
    chk("bp_no_accept", bus.req1_ready, 32'd0);
    tick();
    bus.rsp0_ready = 1'b0;
    chk("bp_idle", bus.busy, 32'd0);
    chk("bp_gnt1", bus.req1_ready, 32'd1);
    tick();
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    chk("bp_rsp1_valid", bus.rsp1_valid, 32'd1);
    chk("bp_rsp1_y", bus.rsp_y, 32'd7);
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;

    // Serve req0 so ptr favours req1, then reset in the middle of a req1 response
    do_op(0, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0000, 32'h0F0F_0000, 1'b0, 4'b0000);
    drive(1, 1'b1, 32'hAAAA_5555, 32'd1, 4'b0001);
    tick();
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    chk("pre_rst_rsp1", bus.rsp1_valid, 32'd1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", bus.busy, 32'd0);
    chk("mid_rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    chk("mid_rst_rsp_y", bus.rsp_y, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    drive(0, 1'b1, 32'd9, 32'd1, 4'b0110);
    drive(1, 1'b1, 32'd2, 32'd2, 4'b0010);
    #1;
    chk("mid_rst_gnt0", {bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    chk("post_rst_rsp0", bus.rsp0_valid, 32'd1);
    chk("post_rst_y", bus.rsp_y, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
